// File: rtl/register_file_sb_pkg.sv
// Shared LEGv8 register-file constants and types.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through).
package regfile_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int XZR        = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] xword_t;
endpackage

// File: rtl/register_file_sb_if.sv
// Read/write/issue bundle between datapath and register file.
// Master = datapath/control side, slave = register file.
interface register_file_sb_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic [AW-1:0]     ReadRegister1;
  logic [AW-1:0]     ReadRegister2;
  logic              ReadUse1;
  logic              ReadUse2;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [DW-1:0]     WriteData;
  logic              IssueValid;
  logic [AW-1:0]     IssueRegister;
  logic [DW-1:0]     ReadData1;
  logic [DW-1:0]     ReadData2;
  logic              Stall;
  logic [2**AW-1:0]  PendingMask;

  modport master (
    output ReadRegister1, ReadRegister2,
    output ReadUse1, ReadUse2,
    output RegWrite, WriteRegister, WriteData,
    output IssueValid, IssueRegister,
    input  ReadData1, ReadData2,
    input  Stall, PendingMask
  );

  modport slave (
    input  ReadRegister1, ReadRegister2,
    input  ReadUse1, ReadUse2,
    input  RegWrite, WriteRegister, WriteData,
    input  IssueValid, IssueRegister,
    output ReadData1, ReadData2,
    output Stall, PendingMask
  );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard for multi-cycle producers plus stall check.
// Optional feature macro: REGFILE_BYPASS_EN (writeback satisfies reads).
module reg_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  rd1_idx_i,
  input  logic [ADDR_WIDTH-1:0]  rd2_idx_i,
  input  logic                   rd1_use_i,
  input  logic                   rd2_use_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_idx_i,
  input  logic                   iss_valid_i,
  input  logic [ADDR_WIDTH-1:0]  iss_idx_i,
  output logic                   stall_o,
  output logic [2**ADDR_WIDTH-1:0] pend_o
);
  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             p1;
  logic             p2;

  // Next pending mask: a new issue beats a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (iss_valid_i && iss_idx_i == ADDR_WIDTH'(i) && i != ZERO_REG)
        pend_d[i] = 1'b1;
      else if (wr_en_i && wr_idx_i == ADDR_WIDTH'(i))
        pend_d[i] = 1'b0;
    end
  end

  // Scoreboard state, dropped entirely on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Per-port pending term, with or without writeback forgiveness.
  always_comb begin
    p1 = pend_q[rd1_idx_i] && (rd1_idx_i != ZR);
    p2 = pend_q[rd2_idx_i] && (rd2_idx_i != ZR);
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && wr_idx_i == rd1_idx_i) p1 = 1'b0;
    if (wr_en_i && wr_idx_i == rd2_idx_i) p2 = 1'b0;
`else
`endif
  end

  assign stall_o = (rd1_use_i & p1) | (rd2_use_i & p2);
  assign pend_o  = pend_q;
endmodule

// File: rtl/register_file_sb.sv
// LEGv8 32x64 register file with XZR and pending-load scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-through reads).
module register_file_sb #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = regfile_pkg::XZR
) (
  input logic          Clock,
  input logic          Reset_n,
  register_file_sb_if.slave bus
);
  import regfile_pkg::*;

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // Writeback port; XZR writes are dropped.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.RegWrite && bus.WriteRegister != ZR) begin
      regs_q[bus.WriteRegister] <= bus.WriteData;
    end
  end

  // Combinational read ports with optional write-through.
  always_comb begin
    rd1 = regs_q[bus.ReadRegister1];
    rd2 = regs_q[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.WriteRegister == bus.ReadRegister1)
      rd1 = bus.WriteData;
    if (bus.RegWrite && bus.WriteRegister == bus.ReadRegister2)
      rd2 = bus.WriteData;
`else
`endif
    if (bus.ReadRegister1 == ZR) rd1 = '0;
    if (bus.ReadRegister2 == ZR) rd2 = '0;
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .rd1_idx_i   (bus.ReadRegister1),
    .rd2_idx_i   (bus.ReadRegister2),
    .rd1_use_i   (bus.ReadUse1),
    .rd2_use_i   (bus.ReadUse2),
    .wr_en_i     (bus.RegWrite),
    .wr_idx_i    (bus.WriteRegister),
    .iss_valid_i (bus.IssueValid),
    .iss_idx_i   (bus.IssueRegister),
    .stall_o     (bus.Stall),
    .pend_o      (bus.PendingMask)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed vector table, reset
// corner case, then random traffic against a reference model.
module tb_register_file_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic Clock;
  logic Reset_n;
  int   passed;
  int   total;

  register_file_sb_if #(.DW(64), .AW(5)) bus ();

  register_file_sb dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        u1;
    logic        u2;
    logic [63:0] e1;
    logic [63:0] e2;
    logic        es;
    logic [31:0] em;
  } vec_t;

  vec_t vt[14];

  logic [63:0] m_regs [32];
  bit          m_pend [32];

  function automatic vec_t mk(
    logic we, logic [4:0] wr, logic [63:0] wd,
    logic iv, logic [4:0] ir,
    logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
    logic [63:0] e1, logic [63:0] e2, logic es, logic [31:0] em);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
    v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.e1 = e1; v.e2 = e2; v.es = es; v.em = em;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(logic we, logic [4:0] wr, logic [63:0] wd,
                       logic iv, logic [4:0] ir, logic [4:0] r1,
                       logic [4:0] r2, logic u1, logic u2);
    bus.RegWrite      = we;
    bus.WriteRegister = wr;
    bus.WriteData     = wd;
    bus.IssueValid    = iv;
    bus.IssueRegister = ir;
    bus.ReadRegister1 = r1;
    bus.ReadRegister2 = r2;
    bus.ReadUse1      = u1;
    bus.ReadUse2      = u2;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom % 8 == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [63:0] m_read(logic [4:0] r, logic we,
                                         logic [4:0] wr, logic [63:0] wd);
    if (r == 5'd31) return 64'd0;
    if (BP && we && wr == r) return wd;
    return m_regs[r];
  endfunction

  function automatic bit m_pnd(logic [4:0] r, logic we, logic [4:0] wr);
    if (r == 5'd31) return 1'b0;
    if (BP && we && wr == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = m_pend[i];
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_reset();

    vt[0]  = mk(0, 0, 0, 0, 0, 5, 31, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 3, 0, 0,
                0, BP ? 64'hDEAD_BEEF_0000_0001 : 64'd0, 0, 0);
    vt[2]  = mk(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 3, 31, 0, 0,
                64'hDEAD_BEEF_0000_0001, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 3, 31, 0, 0,
                64'hDEAD_BEEF_0000_0001, 0, 0, 0);
    vt[4]  = mk(1, 7, 64'h1234, 0, 0, 7, 3, 0, 0,
                BP ? 64'h1234 : 64'd0, 64'hDEAD_BEEF_0000_0001, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 7, 31, 0, 0, 64'h1234, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 1, 9, 7, 9, 0, 1, 64'h1234, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 7, 9, 0, 1, 64'h1234, 0, 1, 32'h200);
    vt[8]  = mk(1, 9, 64'h55, 0, 0, 7, 9, 0, 1, 64'h1234,
                BP ? 64'h55 : 64'd0, !BP, 32'h200);
    vt[9]  = mk(0, 0, 0, 0, 0, 7, 9, 0, 1, 64'h1234, 64'h55, 0, 0);
    vt[10] = mk(0, 0, 0, 1, 4, 4, 9, 0, 0, 0, 64'h55, 0, 0);
    vt[11] = mk(1, 4, 64'hAA, 1, 4, 4, 9, 1, 0,
                BP ? 64'hAA : 64'd0, 64'h55, !BP, 32'h10);
    vt[12] = mk(0, 0, 0, 0, 0, 4, 0, 1, 0, 64'hAA, 0, 1, 32'h10);
    vt[13] = mk(0, 0, 0, 0, 0, 4, 0, 0, 1, 64'hAA, 0, 0, 32'h10);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;

    for (int k = 0; k < 14; k++) begin
      drive(vt[k].we, vt[k].wr, vt[k].wd, vt[k].iv, vt[k].ir,
            vt[k].r1, vt[k].r2, vt[k].u1, vt[k].u2);
      #3;
      chk($sformatf("vec%0d ReadData1", k), bus.ReadData1, vt[k].e1);
      chk($sformatf("vec%0d ReadData2", k), bus.ReadData2, vt[k].e2);
      chk($sformatf("vec%0d Stall", k), 64'(bus.Stall), 64'(vt[k].es));
      chk($sformatf("vec%0d PendingMask", k),
          64'(bus.PendingMask), 64'(vt[k].em));
      @(posedge Clock);
      #1;
    end

    drive(0, 0, 0, 0, 0, 4, 0, 1, 0);
    #3 Reset_n = 1'b0;
    #1;
    chk("midreset PendingMask", 64'(bus.PendingMask), 64'd0);
    chk("midreset ReadData1", bus.ReadData1, 64'd0);
    chk("midreset Stall", 64'(bus.Stall), 64'd0);
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    m_reset();

    for (int c = 0; c < 300; c++) begin
      logic        we, iv, u1, u2;
      logic [4:0]  wr, ir, r1, r2;
      logic [63:0] wd;
      we = 1'($urandom % 2);
      wr = pick();
      wd = {$urandom, $urandom};
      iv = ($urandom % 3 == 0);
      ir = pick();
      r1 = pick();
      r2 = pick();
      u1 = 1'($urandom % 2);
      u2 = 1'($urandom % 2);
      drive(we, wr, wd, iv, ir, r1, r2, u1, u2);
      #3;
      chk("rand ReadData1", bus.ReadData1, m_read(r1, we, wr, wd));
      chk("rand ReadData2", bus.ReadData2, m_read(r2, we, wr, wd));
      chk("rand Stall", 64'(bus.Stall),
          64'((u1 && m_pnd(r1, we, wr)) || (u2 && m_pnd(r2, we, wr))));
      chk("rand PendingMask", 64'(bus.PendingMask), 64'(m_mask()));
      @(posedge Clock);
      #1;
      if (we && wr != 5'd31) m_regs[wr] = wd;
      if (we) m_pend[wr] = 1'b0;
      if (iv && ir != 5'd31) m_pend[ir] = 1'b1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
